lvdc_telem_sched: RTL
=====================

# lvdc_telem_sched

Telemetry readout scheduler for the LVDC simulation. It shares one serial readout channel (frame sync, bit strobe, serial data) among four requesters, each offering a 26-bit word. It grants round-robin and serialises the granted word MSB first, framed by a one-bit-period sync pulse. It sits between LVDC-internal word sources (accumulator, memory, PIO snapshots) and the bench-side serial receiver.

## Interface
- DIV, 8: SIM_CLK cycles per serial bit period; even, ≥2.
- WORD_W, 26: bits per word; fixed at 26.
- SIM_CLK  in  1  sole clock; all logic on rising edge.
- SIM_RST  in  1  synchronous, active-high reset.
- REQ  in  4  per-requester request; level, held until ACK.
- DATA  in  4×26 (104)  flattened words; requester i at [26i+25:26i].
- HALT  in  1  1 = no new grants; a frame in progress completes.
- ACK  out  4  one-hot, one-cycle grant pulse; word captured on this edge.
- CHAN  out  2  index of the current or last granted requester.
- BUSY  out  1  1 from the grant cycle through the last GAP cycle.
- SYNC  out  1  frame sync; high for exactly one bit period.
- STRB  out  1  bit strobe; high in the second half of each SYNC/DATA bit period.
- SDAT  out  1  serial data; MSB first, stable for the whole bit period.
- DONE  out  1  one-cycle pulse on the last GAP cycle.

## Operation
- States: IDLE, SYNC, DATA, GAP.
- Reset values: all outputs 0, state IDLE, rr pointer 3, bit counter 0, divider 0.
- IDLE: if HALT=0 and REQ≠0, choose the first asserted requester in order ptr+1, ptr+2, ptr+3, ptr (mod 4).
  - On that edge: ACK[i]=1, CHAN=i, ptr=i, shift register ← DATA[i], divider ← 0, state → SYNC.
  - HALT=1 or REQ=0: remain in IDLE; ACK stays 0.
- SYNC: SYNC=1, SDAT=0 for DIV cycles. After DIV cycles, state → DATA, bit counter ← 25.
- DATA: SDAT = shift[25] for DIV cycles per bit. At the end of each period, shift left by 1 and decrement the counter. After the period with counter=0, state → GAP.
- GAP: SYNC=0, STRB=0, SDAT=0 for DIV cycles. DONE=1 on the final cycle, then state → IDLE.
- STRB: within each SYNC/DATA period, STRB=1 when divider ≥ DIV/2 and 0 otherwise. This gives DIV/2 cycles high and a rising edge mid-bit.
- ACK is asserted only in the grant cycle. REQ asserted during a frame is held pending, not lost. A requester dropping REQ before ACK forfeits its turn without side effects.
- HALT does not affect a frame in progress. HALT deasserted while in IDLE allows a grant on the next edge.
- DATA is sampled only at the grant edge; later changes do not affect the frame.
- SIM_RST mid-frame: on the next edge all outputs go to 0, state IDLE, ptr 3, and the frame is abandoned with no DONE.

## Timing
- Grant latency: REQ observed in IDLE at edge n gives ACK/BUSY/SYNC high in cycle n+1.
- Frame length: (1 + 26 + 1) × DIV = 28·DIV cycles from ACK to the end of DONE. BUSY is high for exactly 28·DIV cycles.
- First data bit (MSB) appears DIV cycles after the ACK cycle. Bit k (MSB = k=0) starts at ACK + (1+k)·DIV.
- Back-to-back frames: after DONE, one IDLE cycle, then ACK. The minimum SYNC-to-SYNC spacing is 28·DIV+1 cycles.
- Strobe count per frame: 27 rising edges (1 sync + 26 data).
- Divider wraps DIV-1 → 0 at every period boundary. State and bit-counter updates occur only on the wrap.

## Test plan
- REQ=4'b0001, DATA[0]=26'h2AAAAAA, DIV=8 → ACK=0001 one cycle later; SYNC high for 8 cycles; SDAT samples at the 26 data strobes read 1,0,1,0,…; BUSY high 224 cycles; DONE once.
- REQ=4'b1111 held, each word distinct → grants in order 0,1,2,3,0; each captured word matches its DATA; one IDLE cycle between DONE and the next ACK.
- HALT=1 with REQ=4'b0100 → no ACK for 50 cycles. Raise HALT mid-frame on another channel → that frame completes intact and no new grant follows until HALT=0.
- SIM_RST asserted at data bit 10 → next cycle all outputs 0; REQ=0010 then gives a fresh grant to requester 1 (ptr reset to 3, priority 0,1,2,3 with req0 absent), full 28·DIV frame.
- DIV=2, DATA[3]=26'h3FFFFFF → STRB alternates 0/1 each cycle for 27 pulses; SDAT=1 for 52 cycles; frame is 56 cycles.
- Change DATA[2] one cycle after ACK[2] → serialised word equals the value present at the ACK edge.

Source files
------------

// File: rtl/lvdc_telem_sched.sv
// Telemetry readout scheduler: round-robin grant among four word sources, then
// serialisation of the granted word MSB first behind a one-bit-period frame sync.
module lvdc_telem_sched #(
    parameter int DIV    = 8,
    parameter int WORD_W = 26
) (
    input  logic                  SIM_CLK,
    input  logic                  SIM_RST,
    input  logic [3:0]            REQ,
    input  logic [4*WORD_W-1:0]   DATA,
    input  logic                  HALT,
    output logic [3:0]            ACK,
    output logic [1:0]            CHAN,
    output logic                  BUSY,
    output logic                  SYNC,
    output logic                  STRB,
    output logic                  SDAT,
    output logic                  DONE
);

    localparam int DIV_W = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int CNT_W = $clog2(WORD_W);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(DIV / 2);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(WORD_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SYNC,
        ST_DATA,
        ST_GAP
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [DIV_W-1:0]    div_q;
    logic [CNT_W-1:0]    bitcnt_q;
    logic [WORD_W-1:0]   shift_q;
    logic [1:0]          ptr_q;
    logic [3:0]          ack_q;
    logic [1:0]          chan_q;

    logic                wrap;
    logic                grant_vld;
    logic [1:0]          grant_idx;
    logic [1:0]          cand;
    logic                grant_go;

    assign wrap = (div_q == DIV_LAST);

    // Round-robin search starting just after the last granted requester.
    // Walking the offsets from farthest to nearest lets the nearest hit win.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = ptr_q;
        cand      = ptr_q;
        for (int k = 4; k >= 1; k--) begin
            cand = ptr_q + 2'(k);
            if (REQ[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    assign grant_go = (state_q == ST_IDLE) && !HALT && grant_vld;

    always_ff @(posedge SIM_CLK) begin
        if (SIM_RST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (grant_go) state_d = ST_SYNC;
            ST_SYNC: if (wrap) state_d = ST_DATA;
            ST_DATA: if (wrap && bitcnt_q == '0) state_d = ST_GAP;
            ST_GAP:  if (wrap) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Control registers: divider, bit counter, grant bookkeeping.
    always_ff @(posedge SIM_CLK) begin
        if (SIM_RST) begin
            div_q    <= '0;
            bitcnt_q <= '0;
            ptr_q    <= 2'd3;
            ack_q    <= '0;
            chan_q   <= '0;
        end else begin
            ack_q <= '0;
            if (grant_go) begin
                ack_q  <= 4'b0001 << grant_idx;
                chan_q <= grant_idx;
                ptr_q  <= grant_idx;
                div_q  <= '0;
            end else if (state_q != ST_IDLE) begin
                div_q <= wrap ? '0 : div_q + DIV_W'(1);
            end
            if (state_q == ST_SYNC && wrap) begin
                bitcnt_q <= BIT_LAST;
            end else if (state_q == ST_DATA && wrap) begin
                bitcnt_q <= bitcnt_q - CNT_W'(1);
            end
        end
    end

    // The word is captured only on the grant edge; source changes afterwards are ignored.
    always_ff @(posedge SIM_CLK) begin
        if (grant_go) begin
            shift_q <= DATA[int'(grant_idx)*WORD_W +: WORD_W];
        end else if (state_q == ST_DATA && wrap) begin
            shift_q <= shift_q << 1;
        end
    end

    always_comb begin
        ACK  = ack_q;
        CHAN = chan_q;
        BUSY = (state_q != ST_IDLE);
        SYNC = (state_q == ST_SYNC);
        STRB = ((state_q == ST_SYNC) || (state_q == ST_DATA)) && (div_q >= DIV_HALF);
        SDAT = (state_q == ST_DATA) && shift_q[WORD_W-1];
        DONE = (state_q == ST_GAP) && wrap;
    end

endmodule
